// File: rtl/adder_error_monitor.sv
// adder_error_monitor: error-metric stage for a WIDTH-bit approximate adder.
// Counts samples, nonzero-error samples, sum and max of |exact - in_sum|.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           one-cycle pulse, begins a run (IDLE/DONE only)
//   num_samples     samples per run, latched on start
//   in_valid/ready  sample handshake, ready only in RUN
//   in_a, in_b      operands
//   in_sum          adder-under-test result (WIDTH+1 bits)
//   busy, done      RUN/DRAIN and DONE status
//   sample_cnt      samples accepted this run
//   err_cnt         samples with nonzero error distance
//   err_dist_sum    saturating sum of error distances
//   max_err_dist    largest error distance this run
//   sq_err_sum      saturating sum of squared distances
//                   (only when ADDER_ERR_SQ_EN is defined)
//
// Build option: define ADDER_ERR_SQ_EN to add sq_err_sum.

module adder_error_monitor #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 20,
   parameter int ACC_W = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH:0]   in_sum,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [ACC_W-1:0] err_dist_sum,
   output logic [WIDTH:0]   max_err_dist
`ifdef ADDER_ERR_SQ_EN
   ,
   output logic [2*ACC_W-1:0] sq_err_sum
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ONE_C = 1;

   state_t           r_state;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_sample_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [ACC_W-1:0] r_dist_sum;
   logic [WIDTH:0]   r_max;
   logic [WIDTH:0]   r_s1_ed;
   logic             r_s1_vld;

   logic             w_accept;
   logic [WIDTH:0]   w_exact;
   logic [WIDTH:0]   w_ed;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_last;
   logic [ACC_W:0]   w_dist_ext;
   logic [ACC_W-1:0] w_dist_next;
   logic [CNT_W-1:0] w_err_next;
   logic [WIDTH:0]   w_max_next;

   // Stage 1: exact sum and absolute error distance of the incoming sample
   assign w_accept  = in_valid && (r_state == S_RUN);
   assign w_exact   = {1'b0, in_a} + {1'b0, in_b};
   assign w_ed      = (w_exact >= in_sum) ? (w_exact - in_sum)
                                          : (in_sum - w_exact);
   assign w_cnt_inc = r_sample_cnt + ONE_C;
   assign w_last    = (w_cnt_inc == r_target);

   // Stage 2: accumulate; the extra top bit of the sum detects overflow
   assign w_dist_ext  = {1'b0, r_dist_sum}
                      + {{(ACC_W-WIDTH){1'b0}}, r_s1_ed};
   assign w_dist_next = w_dist_ext[ACC_W] ? {ACC_W{1'b1}}
                                          : w_dist_ext[ACC_W-1:0];
   assign w_err_next  = (r_s1_ed != '0) ? (r_err_cnt + ONE_C)
                                        : r_err_cnt;
   assign w_max_next  = (r_s1_ed > r_max) ? r_s1_ed : r_max;

`ifdef ADDER_ERR_SQ_EN
   logic [2*ACC_W-1:0] r_sq_sum;
   logic [2*WIDTH+1:0] w_ed_x;
   logic [2*WIDTH+1:0] w_sq;
   logic [2*ACC_W:0]   w_sq_ext;
   logic [2*ACC_W-1:0] w_sq_next;

   // Operands widened first so the product keeps all 2*(WIDTH+1) bits
   assign w_ed_x    = {{(WIDTH+1){1'b0}}, r_s1_ed};
   assign w_sq      = w_ed_x * w_ed_x;
   assign w_sq_ext  = {1'b0, r_sq_sum}
                    + {{(2*ACC_W-2*WIDTH-1){1'b0}}, w_sq};
   assign w_sq_next = w_sq_ext[2*ACC_W] ? {(2*ACC_W){1'b1}}
                                        : w_sq_ext[2*ACC_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sq_sum <= '0;
      end else if (start &&
                   (r_state == S_IDLE || r_state == S_DONE)) begin
         r_sq_sum <= '0;
      end else if (r_s1_vld) begin
         r_sq_sum <= w_sq_next;
      end
   end

   assign sq_err_sum = r_sq_sum;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_target     <= '0;
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_dist_sum   <= '0;
         r_max        <= '0;
         r_s1_ed      <= '0;
         r_s1_vld     <= 1'b0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_s1_ed      <= w_ed;
            r_sample_cnt <= w_cnt_inc;
         end
         if (r_s1_vld) begin
            r_err_cnt  <= w_err_next;
            r_dist_sum <= w_dist_next;
            r_max      <= w_max_next;
         end
         unique case (r_state)
            S_IDLE, S_DONE: begin
               // Stage 1 is always empty here, so clearing cannot race
               // with an accumulate
               if (start) begin
                  r_target     <= num_samples;
                  r_sample_cnt <= '0;
                  r_err_cnt    <= '0;
                  r_dist_sum   <= '0;
                  r_max        <= '0;
                  r_state      <= (num_samples == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept && w_last) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Last sample is accumulated on this edge when stage 1
               // still holds it; leave once it has gone through
               if (!r_s1_vld) begin
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready     = (r_state == S_RUN);
   assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done         = (r_state == S_DONE);
   assign sample_cnt   = r_sample_cnt;
   assign err_cnt      = r_err_cnt;
   assign err_dist_sum = r_dist_sum;
   assign max_err_dist = r_max;

endmodule
